// File: rtl/divider_32bits.sv
// rtl/divider_32bits.sv - multi-cycle restoring divider (DIV/DIVU) producing LO/HI with start/done handshake
// Define DIVIDER_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module divider_32bits #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dvd_raw;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_neg_q;
  logic             w_neg_r;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

`ifdef DIVIDER_SIGNED_EN
  logic w_dvd_neg;
  logic w_dvs_neg;

  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg = is_signed & divisor[WIDTH-1];
  // Most-negative operand maps to itself, which is still the correct unsigned magnitude.
  assign w_dvd_mag = w_dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
  assign w_neg_q   = w_dvd_neg ^ w_dvs_neg;
  assign w_neg_r   = w_dvd_neg;
`else
  logic w_unused_is_signed;

  assign w_unused_is_signed = is_signed;
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_neg_q   = 1'b0;
  assign w_neg_r   = 1'b0;
`endif

  // Borrow out of the WIDTH+1-bit subtract (bit WIDTH) means the trial went negative.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_fix_q = r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_fix_r = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_RUN;
      end
      S_RUN:  if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_dvd_raw   <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_zero      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_quo       <= w_dvd_mag;
            r_dvs       <= w_dvs_mag;
            r_rem       <= '0;
            r_dvd_raw   <= dividend;
            r_neg_q     <= w_neg_q;
            r_neg_r     <= w_neg_r;
            r_zero      <= (divisor == '0);
            r_cnt       <= CW'(WIDTH);
            div_by_zero <= 1'b0;
          end
        end
        S_RUN: begin
          r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          quotient    <= r_zero ? '1 : w_fix_q;
          remainder   <= r_zero ? r_dvd_raw : w_fix_r;
          div_by_zero <= r_zero;
        end
        default: ;
      endcase
    end
  end

endmodule
